// File: rtl/seq_tx_sched.sv
// seq_tx_sched - round-robin frame transmit scheduler for the serial link.
//
// Up to NREQ local requesters share one serial line. Each grant sends one
// 48-bit frame MSB first: HEAD, data0..data3 (payload[31:0], data0 in the
// top byte) and the 8-bit wrap-around sum of the four data bytes. An idle
// gap of GAP cycles follows every frame.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   req       in   [NREQ]    level request per requester, held until ack
//   payload   in   [32*NREQ] requester i at [32i+31:32i]
//   ack       out  [NREQ]    one-cycle pulse when a payload is latched
//   sout      out  serial frame output, idles low
//   sof       out  pulse during the first header bit
//   eof       out  pulse during the last checksum bit
//   busy      out  high whenever a frame or its gap is in progress
//   grant_id  out  [2]       requester being served, held until next grant
module seq_tx_sched #(
  parameter int          NREQ = 4,
  parameter logic [7:0]  HEAD = 8'b1101_0010,
  parameter int          GAP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [32*NREQ-1:0] payload,
  output logic [NREQ-1:0]    ack,
  output logic               sout,
  output logic               sof,
  output logic               eof,
  output logic               busy,
  output logic [1:0]         grant_id
);

  // The bit counter is shared by all states, so it must also cover the gap.
  localparam int CW = ($clog2(GAP) > 6) ? $clog2(GAP) : 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_DATA,
    S_SUM,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_bitcnt;
  logic [1:0]      r_ptr;
  logic [47:0]     r_shift;
  logic            r_sout;
  logic [NREQ-1:0] r_ack;
  logic [1:0]      r_grantId;

  logic            w_grantValid;
  logic [1:0]      w_grant;
  logic [31:0]     w_payload;
  logic [7:0]      w_cks;
  logic [47:0]     w_frame;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: each serialising state lasts a fixed number of bits,
  // counted from zero on entry.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_grantValid)                   w_nextState = S_HEAD;
      S_HEAD: if (r_bitcnt == CW'(7))             w_nextState = S_DATA;
      S_DATA: if (r_bitcnt == CW'(31))            w_nextState = S_SUM;
      S_SUM:  if (r_bitcnt == CW'(7))             w_nextState = S_GAP;
      S_GAP:  if (r_bitcnt == CW'(GAP - 1))       w_nextState = S_IDLE;
      default:                                    w_nextState = S_IDLE;
    endcase
  end

  // Rotating-priority arbiter: the first active request at or after the
  // pointer wins. Only consulted while idle.
  always_comb begin
    w_grantValid = 1'b0;
    w_grant      = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_grantValid && req[(int'(r_ptr) + k) % NREQ]) begin
        w_grantValid = 1'b1;
        w_grant      = 2'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Pick the winner's payload lane.
  always_comb begin
    w_payload = 32'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == 2'(i)) begin
        w_payload = payload[32*i +: 32];
      end
    end
  end

  // 8-bit sum, carry discarded, matching the receiver's check.
  assign w_cks   = w_payload[31:24] + w_payload[23:16] + w_payload[15:8] + w_payload[7:0];
  assign w_frame = {HEAD, w_payload, w_cks};

  // Datapath. The shift register doubles as the payload holding register,
  // so later payload changes cannot disturb a frame in flight. On the grant
  // edge the first bit goes straight to sout and the register is preloaded
  // one position ahead, so sout is always the registered MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitcnt  <= '0;
      r_ptr     <= 2'd0;
      r_shift   <= 48'd0;
      r_sout    <= 1'b0;
      r_ack     <= '0;
      r_grantId <= 2'd0;
    end else begin
      r_ack <= '0;
      if (r_state == S_IDLE || w_nextState != r_state) begin
        r_bitcnt <= '0;
      end else begin
        r_bitcnt <= r_bitcnt + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_sout <= 1'b0;
          if (w_grantValid) begin
            r_shift   <= {w_frame[46:0], 1'b0};
            r_sout    <= w_frame[47];
            r_ack     <= {{(NREQ-1){1'b0}}, 1'b1} << w_grant;
            r_grantId <= w_grant;
            r_ptr     <= (w_grant == 2'(NREQ - 1)) ? 2'd0 : w_grant + 2'd1;
          end
        end
        S_HEAD, S_DATA, S_SUM: begin
          r_sout  <= r_shift[47];
          r_shift <= {r_shift[46:0], 1'b0};
        end
        default: begin
          r_sout  <= 1'b0;
          r_shift <= 48'd0;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign sout     = r_sout;
  assign grant_id = r_grantId;
  assign busy     = (r_state != S_IDLE);
  assign sof      = (r_state == S_HEAD) && (r_bitcnt == CW'(0));
  assign eof      = (r_state == S_SUM)  && (r_bitcnt == CW'(7));

endmodule
